// File: rtl/ovi_issue_scheduler.sv
// OVI issue scheduler: queues core vector instructions, issues them against
// VPU credits, dispatches each issued instruction as senior one cycle later,
// and forwards in-order completions back to the core.
module ovi_issue_scheduler #(
   parameter int unsigned CREDITS_INIT = 4,
   parameter int unsigned QDEPTH       = 4,
   parameter int unsigned SBID_W       = 5,
   parameter int unsigned MAXOUT       = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CORE_VALID,
   input  logic [31:0]       CORE_INSTR,
   input  logic [63:0]       CORE_SCALAR,
   output logic              CORE_READY,
   input  logic              CORE_FLUSH,
   output logic              VPU_ISSUE_VALID,
   output logic [31:0]       VPU_ISSUE_INSTR,
   output logic [63:0]       VPU_ISSUE_SCALAR,
   output logic [SBID_W-1:0] VPU_ISSUE_SBID,
   input  logic              VPU_ISSUE_CREDIT,
   output logic              VPU_DISPATCH_NEXT_SENIOR,
   output logic              VPU_DISPATCH_KILL,
   output logic [SBID_W-1:0] VPU_DISPATCH_SBID,
   input  logic              VPU_COMPLETED_VALID,
   input  logic [SBID_W-1:0] VPU_COMPLETED_SBID,
   input  logic [63:0]       VPU_COMPLETED_DEST,
   output logic              CORE_COMPLETED_VALID,
   output logic [63:0]       CORE_COMPLETED_DATA,
   output logic              CREDIT_ERR
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = $clog2(CREDITS_INIT + 1);
   localparam int unsigned OUT_W = $clog2(MAXOUT + 1);

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e              r_state, w_state_d;
   logic [31:0]         r_q_instr  [QDEPTH];
   logic [63:0]         r_q_scalar [QDEPTH];
   logic [PTR_W:0]      r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]    r_credits, w_credits_d;
   logic [OUT_W-1:0]    r_out, w_out_d;
   logic [SBID_W-1:0]   r_next_sbid, r_oldest_sbid;
   logic                r_disp_valid;
   logic [SBID_W-1:0]   r_disp_sbid;
   logic                r_cmp_valid;
   logic [63:0]         r_cmp_data;
   logic                r_err;

   logic w_empty, w_full, w_enq, w_issue, w_cmp_ok, w_cmp_bad, w_cred_ovf, w_flush;

   // Queue status; the pointer MSB distinguishes full from empty.
   always_comb begin
      w_empty = (r_wr_ptr == r_rd_ptr);
      w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   end

   // Handshake, issue qualification and completion matching.
   always_comb begin
      CORE_READY = (r_state == StRun) && !w_full;
      w_flush    = (r_state == StRun) && CORE_FLUSH;
      w_enq      = CORE_VALID && CORE_READY && !CORE_FLUSH;
      w_issue    = (r_state == StRun) && !w_empty && (r_credits != '0) &&
                   (r_out < OUT_W'(MAXOUT)) && !CORE_FLUSH;
      w_cmp_ok   = VPU_COMPLETED_VALID && (VPU_COMPLETED_SBID == r_oldest_sbid) &&
                   (r_out != '0);
      w_cmp_bad  = VPU_COMPLETED_VALID && !w_cmp_ok;
   end

   // Credit accounting; a return at the ceiling with no issue is a protocol error.
   always_comb begin
      w_credits_d = r_credits;
      w_cred_ovf  = 1'b0;
      if (VPU_ISSUE_CREDIT && !w_issue && (r_credits == CNT_W'(CREDITS_INIT))) begin
         w_cred_ovf = 1'b1;
      end else begin
         w_credits_d = r_credits - CNT_W'(w_issue) + CNT_W'(VPU_ISSUE_CREDIT);
      end
      w_out_d = r_out + OUT_W'(w_issue) - OUT_W'(w_cmp_ok);
   end

   // Next state: flush drains in-flight work; resume once nothing is outstanding.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StRun:   if (CORE_FLUSH) w_state_d = StDrain;
         StDrain: if (w_out_d == '0) w_state_d = StRun;
         default: w_state_d = StRun;
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) r_state <= StRun;
      else     r_state <= w_state_d;
   end

   // Queue storage; contents need no reset since issue data is gated by w_issue.
   always_ff @(posedge CLK) begin
      if (w_enq) begin
         r_q_instr[r_wr_ptr[PTR_W-1:0]]  <= CORE_INSTR;
         r_q_scalar[r_wr_ptr[PTR_W-1:0]] <= CORE_SCALAR;
      end
   end

   // Pointers, counters, dispatch and completion registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_credits     <= CNT_W'(CREDITS_INIT);
         r_out         <= '0;
         r_next_sbid   <= '0;
         r_oldest_sbid <= '0;
         r_disp_valid  <= 1'b0;
         r_disp_sbid   <= '0;
         r_cmp_valid   <= 1'b0;
         r_cmp_data    <= '0;
         r_err         <= 1'b0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_flush)      r_rd_ptr <= r_wr_ptr;
         else if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_issue)  r_next_sbid   <= r_next_sbid + 1'b1;
         if (w_cmp_ok) r_oldest_sbid <= r_oldest_sbid + 1'b1;
         r_credits    <= w_credits_d;
         r_out        <= w_out_d;
         r_disp_valid <= w_issue;
         r_disp_sbid  <= w_issue ? r_next_sbid : '0;
         r_cmp_valid  <= w_cmp_ok;
         r_cmp_data   <= w_cmp_ok ? VPU_COMPLETED_DEST : '0;
         r_err        <= r_err | w_cred_ovf | w_cmp_bad;
      end
   end

   // Issue bus is combinational from the queue head, zero when idle.
   always_comb begin
      VPU_ISSUE_VALID  = w_issue;
      VPU_ISSUE_INSTR  = w_issue ? r_q_instr[r_rd_ptr[PTR_W-1:0]]  : '0;
      VPU_ISSUE_SCALAR = w_issue ? r_q_scalar[r_rd_ptr[PTR_W-1:0]] : '0;
      VPU_ISSUE_SBID   = w_issue ? r_next_sbid : '0;
   end

   assign VPU_DISPATCH_NEXT_SENIOR = r_disp_valid;
   assign VPU_DISPATCH_KILL        = 1'b0;
   assign VPU_DISPATCH_SBID        = r_disp_sbid;
   assign CORE_COMPLETED_VALID     = r_cmp_valid;
   assign CORE_COMPLETED_DATA      = r_cmp_data;
   assign CREDIT_ERR               = r_err;

endmodule

// File: tb/tb_ovi_issue_scheduler.sv
// Scoreboard bench for ovi_issue_scheduler: stimulus pushes expected issue,
// dispatch and completion records; a negedge monitor pops and compares.
module tb_ovi_issue_scheduler;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST = 1'b1;
   logic        core_valid = 0, core_flush = 0, credit = 0;
   logic [31:0] core_instr = '0;
   logic [63:0] core_scalar = '0;
   logic        cmp_valid = 0;
   logic [4:0]  cmp_sbid = '0;
   logic [63:0] cmp_dest = '0;
   logic        core_ready, iss_valid, disp_valid, disp_kill, ccmp_valid, err;
   logic [31:0] iss_instr;
   logic [63:0] iss_scalar, ccmp_data;
   logic [4:0]  iss_sbid, disp_sbid;

   // Second instance with a 2-bit sb_id to exercise wrap-around.
   logic        b_valid = 0, b_credit = 0, b_cmp_valid = 0;
   logic [31:0] b_instr = '0;
   logic [1:0]  b_cmp_sbid = '0;
   logic [63:0] b_cmp_dest = '0;
   logic        b_ready, b_iss_valid, b_disp_valid, b_kill, b_ccmp_valid, b_err;
   logic [31:0] b_iss_instr;
   logic [63:0] b_iss_scalar, b_ccmp_data;
   logic [1:0]  b_iss_sbid, b_disp_sbid;

   ovi_issue_scheduler dut (
      .CLK(CLK), .RST(RST), .CORE_VALID(core_valid), .CORE_INSTR(core_instr),
      .CORE_SCALAR(core_scalar), .CORE_READY(core_ready), .CORE_FLUSH(core_flush),
      .VPU_ISSUE_VALID(iss_valid), .VPU_ISSUE_INSTR(iss_instr),
      .VPU_ISSUE_SCALAR(iss_scalar), .VPU_ISSUE_SBID(iss_sbid),
      .VPU_ISSUE_CREDIT(credit), .VPU_DISPATCH_NEXT_SENIOR(disp_valid),
      .VPU_DISPATCH_KILL(disp_kill), .VPU_DISPATCH_SBID(disp_sbid),
      .VPU_COMPLETED_VALID(cmp_valid), .VPU_COMPLETED_SBID(cmp_sbid),
      .VPU_COMPLETED_DEST(cmp_dest), .CORE_COMPLETED_VALID(ccmp_valid),
      .CORE_COMPLETED_DATA(ccmp_data), .CREDIT_ERR(err)
   );

   ovi_issue_scheduler #(.CREDITS_INIT(4), .QDEPTH(4), .SBID_W(2), .MAXOUT(4)) dut2 (
      .CLK(CLK), .RST(RST), .CORE_VALID(b_valid), .CORE_INSTR(b_instr),
      .CORE_SCALAR(64'h0), .CORE_READY(b_ready), .CORE_FLUSH(1'b0),
      .VPU_ISSUE_VALID(b_iss_valid), .VPU_ISSUE_INSTR(b_iss_instr),
      .VPU_ISSUE_SCALAR(b_iss_scalar), .VPU_ISSUE_SBID(b_iss_sbid),
      .VPU_ISSUE_CREDIT(b_credit), .VPU_DISPATCH_NEXT_SENIOR(b_disp_valid),
      .VPU_DISPATCH_KILL(b_kill), .VPU_DISPATCH_SBID(b_disp_sbid),
      .VPU_COMPLETED_VALID(b_cmp_valid), .VPU_COMPLETED_SBID(b_cmp_sbid),
      .VPU_COMPLETED_DEST(b_cmp_dest), .CORE_COMPLETED_VALID(b_ccmp_valid),
      .CORE_COMPLETED_DATA(b_ccmp_data), .CREDIT_ERR(b_err)
   );

   typedef struct {
      logic [31:0] instr;
      logic [63:0] scalar;
      logic [4:0]  sbid;
   } iss_t;

   iss_t        exp_iss[$];
   logic [4:0]  exp_disp[$];
   logic [63:0] exp_cmp[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic        prev_issue = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_issue(input logic [31:0] instr, input logic [63:0] scalar,
                               input logic [4:0] sbid);
      iss_t e;
      e.instr = instr; e.scalar = scalar; e.sbid = sbid;
      exp_iss.push_back(e);
      exp_disp.push_back(sbid);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_iss_valid"}, iss_valid, 0);
      chk({tag, "_iss_sbid"}, iss_sbid, 0);
      chk({tag, "_disp"}, disp_valid, 0);
      chk({tag, "_disp_sbid"}, disp_sbid, 0);
      chk({tag, "_cmp_valid"}, ccmp_valid, 0);
      chk({tag, "_cmp_data"}, ccmp_data, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_ready"}, core_ready, 1);
      chk({tag, "_kill"}, disp_kill, 0);
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_iss_pending"}, 64'(exp_iss.size()), 0);
      chk({tag, "_disp_pending"}, 64'(exp_disp.size()), 0);
      chk({tag, "_cmp_pending"}, 64'(exp_cmp.size()), 0);
   endtask

   // Monitor: compare every DUT output event against the scoreboard queues.
   always @(negedge CLK) begin
      if (iss_valid) begin
         if (exp_iss.size() == 0) begin
            chk("unexpected_issue", {32'h0, iss_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            iss_t e;
            e = exp_iss.pop_front();
            chk("issue_instr", iss_instr, e.instr);
            chk("issue_scalar", iss_scalar, e.scalar);
            chk("issue_sbid", iss_sbid, e.sbid);
         end
      end
      if (disp_valid || prev_issue) chk("dispatch_timing", disp_valid, prev_issue);
      if (disp_valid) begin
         if (exp_disp.size() == 0) chk("unexpected_dispatch", disp_sbid, 5'h1f);
         else chk("dispatch_sbid", disp_sbid, exp_disp.pop_front());
      end
      if (ccmp_valid) begin
         if (exp_cmp.size() == 0) chk("unexpected_completion", ccmp_data, 64'hFFFF);
         else chk("completion_data", ccmp_data, exp_cmp.pop_front());
      end
      prev_issue = iss_valid && !RST;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      RST = 1'b1;
      cyc(); cyc();
      RST = 1'b0;
      @(negedge CLK);
      chk_reset_outputs("reset");
      cyc();

      // Six pushes, four credits: sbids 0..3 issue, two stay queued.
      for (int i = 0; i < 4; i++) expect_issue(32'h57 + 32'(i) * 32'h100, 64'(i), 5'(i));
      for (int i = 0; i < 6; i++) begin
         core_valid = 1; core_instr = 32'h57 + 32'(i) * 32'h100; core_scalar = 64'(i);
         @(negedge CLK);
         chk("t1_ready", core_ready, 1);
         cyc();
      end
      core_valid = 0;
      repeat (4) cyc();
      @(negedge CLK);
      chk("t1_ready_after", core_ready, 1);
      chk_drained("t1");
      cyc();

      // Credit return releases exactly one issue (sbid 4).
      expect_issue(32'h457, 64'd4, 5'd4);
      credit = 1;
      @(negedge CLK);
      chk("t2_no_issue_in_credit_cycle", iss_valid, 0);
      cyc();
      credit = 0;
      @(negedge CLK);
      chk("t2_issue_after_credit", iss_valid, 1);
      cyc();
      repeat (3) cyc();
      expect_issue(32'h557, 64'd5, 5'd5);
      credit = 1;
      @(negedge CLK);
      chk("t2_no_issue_second_credit_cycle", iss_valid, 0);
      cyc();
      // Issue and credit return together: credit count stays at 1.
      @(negedge CLK);
      chk("t2_issue_with_credit", iss_valid, 1);
      cyc();
      credit = 0;
      expect_issue(32'h757, 64'd6, 5'd6);
      core_valid = 1; core_instr = 32'h757; core_scalar = 64'd6;
      cyc();
      core_valid = 0;
      @(negedge CLK);
      chk("t2_issue_retained_credit", iss_valid, 1);
      cyc();
      cyc();
      chk_drained("t2");

      // In-order completions, then an out-of-order sb_id is dropped.
      exp_cmp.push_back(64'hA);
      exp_cmp.push_back(64'hB);
      cmp_valid = 1; cmp_sbid = 5'd0; cmp_dest = 64'hA;
      cyc();
      cmp_sbid = 5'd1; cmp_dest = 64'hB;
      cyc();
      cmp_sbid = 5'd3; cmp_dest = 64'hC;
      cyc();
      cmp_valid = 0;
      @(negedge CLK);
      chk("t3_dropped_no_valid", ccmp_valid, 0);
      chk("t3_err_set", err, 1);
      cyc();
      chk_drained("t3");

      // Flush with 3 queued and 2 outstanding.
      RST = 1;
      cyc();
      RST = 0;
      @(negedge CLK);
      chk_reset_outputs("reset2");
      cyc();
      for (int i = 0; i < 4; i++) expect_issue(32'h1000 + 32'(i), 64'(i), 5'(i));
      for (int i = 0; i < 4; i++) begin
         core_valid = 1; core_instr = 32'h1000 + 32'(i); core_scalar = 64'(i);
         cyc();
      end
      core_valid = 0;
      cyc(); cyc();
      exp_cmp.push_back(64'h10);
      exp_cmp.push_back(64'h11);
      cmp_valid = 1; cmp_sbid = 5'd0; cmp_dest = 64'h10;
      cyc();
      cmp_sbid = 5'd1; cmp_dest = 64'h11;
      cyc();
      cmp_valid = 0;
      for (int i = 0; i < 3; i++) begin
         core_valid = 1; core_instr = 32'hDEAD_0000 + 32'(i); core_scalar = 64'hBAD;
         credit = (i == 2);
         cyc();
      end
      credit = 0;
      // Flush cycle: a credit is available, yet nothing may issue or enqueue.
      core_flush = 1; core_instr = 32'hBAD;
      @(negedge CLK);
      chk("t4_flush_gates_issue", iss_valid, 0);
      cyc();
      core_flush = 0;
      @(negedge CLK);
      chk("t4_drain_ready0_a", core_ready, 0);
      cyc();
      exp_cmp.push_back(64'h12);
      exp_cmp.push_back(64'h13);
      cmp_valid = 1; cmp_sbid = 5'd2; cmp_dest = 64'h12;
      @(negedge CLK);
      chk("t4_drain_ready0_b", core_ready, 0);
      cyc();
      cmp_sbid = 5'd3; cmp_dest = 64'h13;
      @(negedge CLK);
      chk("t4_drain_ready0_c", core_ready, 0);
      cyc();
      cmp_valid = 0;
      expect_issue(32'h2000, 64'h99, 5'd4);
      core_valid = 1; core_instr = 32'h2000; core_scalar = 64'h99;
      @(negedge CLK);
      chk("t4_ready_after_drain", core_ready, 1);
      cyc();
      core_valid = 0;
      repeat (3) cyc();
      chk_drained("t4");

      // Credit overflow at the ceiling.
      credit = 1;
      repeat (4) cyc();
      credit = 0;
      @(negedge CLK);
      chk("t5_no_err_at_ceiling", err, 0);
      cyc();
      credit = 1;
      cyc();
      credit = 0;
      @(negedge CLK);
      chk("t5_err_on_overflow", err, 1);
      cyc();
      for (int i = 0; i < 4; i++) expect_issue(32'h3000 + 32'(i), 64'(i), 5'(5 + i));
      for (int i = 0; i < 5; i++) begin
         core_valid = 1; core_instr = 32'h3000 + 32'(i); core_scalar = 64'(i);
         cyc();
      end
      core_valid = 0;
      repeat (3) cyc();
      chk_drained("t5");

      // Reset mid-traffic; a completion presented during reset is discarded.
      RST = 1; cmp_valid = 1; cmp_sbid = 5'd4; cmp_dest = 64'hDEAD;
      cyc();
      RST = 0; cmp_valid = 0;
      @(negedge CLK);
      chk_reset_outputs("reset3");
      cyc();
      for (int i = 0; i < 4; i++) expect_issue(32'h4000 + 32'(i), 64'(i), 5'(i));
      for (int i = 0; i < 5; i++) begin
         core_valid = 1; core_instr = 32'h4000 + 32'(i); core_scalar = 64'(i);
         cyc();
      end
      core_valid = 0;
      repeat (4) cyc();
      chk_drained("t6");

      // sb_id wrap with a 2-bit sb_id on the second instance.
      for (int i = 0; i < 10; i++) begin
         b_valid = 1; b_instr = 32'h57 + 32'(i);
         cyc();
         b_valid = 0;
         @(negedge CLK);
         chk("wrap_issue_valid", b_iss_valid, 1);
         chk("wrap_issue_sbid", b_iss_sbid, 64'(i % 4));
         cyc();
         b_cmp_valid = 1; b_cmp_sbid = 2'(i % 4); b_cmp_dest = 64'h100 + 64'(i); b_credit = 1;
         cyc();
         b_cmp_valid = 0; b_credit = 0;
         @(negedge CLK);
         chk("wrap_cmp_valid", b_ccmp_valid, 1);
         chk("wrap_cmp_data", b_ccmp_data, 64'h100 + 64'(i));
         cyc();
      end
      @(negedge CLK);
      chk("wrap_no_err", b_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
